// File: rtl/ts_freq_counter_if.sv
// Wishbone slave bus bundle for the test-structure frequency counter.
//
// Handshake: a request is live while wbs_cyc_i & wbs_stb_i are high and the
// address decodes to this block. The slave raises wbs_ack_o exactly one
// cycle later and holds it for one cycle only. The master keeps every
// request signal stable through that ack cycle and may then drop them or
// start a new request. Read data is only meaningful while wbs_ack_o is high.
interface ts_freq_counter_if;
   logic        wbs_stb_i;
   logic        wbs_cyc_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i;
   logic [31:0] wbs_dat_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;

   modport master (
      output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      input  wbs_ack_o, wbs_dat_o
   );

   modport slave (
      input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      output wbs_ack_o, wbs_dat_o
   );
endinterface

// File: rtl/ts_freq_counter.sv
// Frequency counter for the gf180 test structures. Enables one selected
// structure, synchronises its output into wb_clk_i, counts rising edges over
// a programmable window of wb_clk_i cycles and reports the count over
// Wishbone with an optional level interrupt.
module ts_freq_counter #(
   parameter int          N_CH     = 8,
   parameter int          CNT_W    = 32,
   parameter logic [31:0] BASE_ADR = 32'h3000_0000,
   parameter int          SETTLE   = 4
) (
   input  logic            wb_clk_i,
   input  logic            wb_rst_i,
   ts_freq_counter_if.slave wbs,
   input  logic [N_CH-1:0] ts_in,
   output logic [N_CH-1:0] ts_en_o,
   output logic            irq_o,
   output logic [1:0]      state_dbg
);

   localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int ST_W  = $clog2(SETTLE);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_COUNT  = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t             state;
   logic [SEL_W-1:0]   sel_reg;
   logic [SEL_W-1:0]   sel_q;
   logic               irq_en;
   logic               done_flag;
   logic               ovf_flag;
   logic [31:0]        window_reg;
   logic [31:0]        win_cnt;
   logic [CNT_W-1:0]   edge_cnt;
   logic [CNT_W-1:0]   result_reg;
   logic [ST_W-1:0]    settle_cnt;
   logic               sync1, sync2, sync3;

   logic               hit, req, wr;
   logic               wr_ctrl, wr_window, wr_status;
   logic               start_w, abort_w, done_clr, ovf_clr;
   logic               busy, start_ok, sel_ok, edge_det;
   logic [SEL_W-1:0]   sel_new;
   logic               irq_en_new, done_new;
   logic [31:0]        rd_data;

   function automatic logic [N_CH-1:0] onehot(input logic [SEL_W-1:0] s);
      logic [N_CH-1:0] r;
      r    = '0;
      r[s] = 1'b1;
      return r;
   endfunction

   assign state_dbg = state;
   assign busy      = (state != S_IDLE);
   assign edge_det  = sync2 & ~sync3;

   // Address decode and write strobes; writes take effect in the ack cycle.
   always_comb begin
      hit       = (wbs.wbs_adr_i[31:4] == BASE_ADR[31:4]);
      req       = wbs.wbs_stb_i & wbs.wbs_cyc_i & hit;
      wr        = req & wbs.wbs_we_i & wbs.wbs_ack_o;
      wr_ctrl   = wr & (wbs.wbs_adr_i[3:2] == 2'd0);
      wr_window = wr & (wbs.wbs_adr_i[3:2] == 2'd1);
      wr_status = wr & (wbs.wbs_adr_i[3:2] == 2'd3);
      start_w   = wr_ctrl & wbs.wbs_sel_i[0] & wbs.wbs_dat_i[0];
      abort_w   = wr_ctrl & wbs.wbs_sel_i[0] & wbs.wbs_dat_i[2];
      done_clr  = wr_status & wbs.wbs_sel_i[0] & wbs.wbs_dat_i[1];
      ovf_clr   = wr_status & wbs.wbs_sel_i[0] & wbs.wbs_dat_i[2];
      sel_new   = (wr_ctrl & wbs.wbs_sel_i[1]) ? wbs.wbs_dat_i[8 +: SEL_W] : sel_reg;
      irq_en_new = (wr_ctrl & wbs.wbs_sel_i[0]) ? wbs.wbs_dat_i[1] : irq_en;
      sel_ok    = ({1'b0, sel_new} < (SEL_W+1)'(N_CH));
      // ABORT in the same write beats START; out-of-range SEL is never started.
      start_ok  = start_w & ~abort_w & ~busy & sel_ok;
   end

   // Next DONE value: FSM completion beats a simultaneous W1C.
   always_comb begin
      done_new = done_flag;
      if (start_ok || done_clr) done_new = 1'b0;
      if (state == S_DONE && !abort_w) done_new = 1'b1;
   end

   // Register read mux; unused bits read as zero.
   always_comb begin
      rd_data = '0;
      case (wbs.wbs_adr_i[3:2])
         2'd0: begin
            rd_data[1]            = irq_en;
            rd_data[8 +: SEL_W]   = sel_reg;
         end
         2'd1: rd_data = window_reg;
         2'd2: rd_data[CNT_W-1:0] = result_reg;
         default: rd_data[2:0] = {ovf_flag, done_flag, busy};
      endcase
   end

   // Single-cycle ack one cycle after the request, read data only with ack.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         wbs.wbs_ack_o <= 1'b0;
         wbs.wbs_dat_o <= '0;
      end else begin
         wbs.wbs_ack_o <= req & ~wbs.wbs_ack_o;
         wbs.wbs_dat_o <= (req & ~wbs.wbs_ack_o & ~wbs.wbs_we_i) ? rd_data : '0;
      end
   end

   // Software-writable configuration: WINDOW bytes, SEL and IRQ_EN.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         window_reg <= '0;
         sel_reg    <= '0;
         irq_en     <= 1'b0;
      end else begin
         for (int b = 0; b < 4; b++) begin
            if (wr_window && wbs.wbs_sel_i[b]) window_reg[8*b +: 8] <= wbs.wbs_dat_i[8*b +: 8];
         end
         sel_reg <= sel_new;
         irq_en  <= irq_en_new;
      end
   end

   // Two-flop synchroniser on the selected channel plus an edge-detect flop.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         sync3 <= 1'b0;
      end else begin
         sync1 <= ts_in[sel_q];
         sync2 <= sync1;
         sync3 <= sync2;
      end
   end

   // Measurement FSM with its counters, flags, enable and interrupt.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state      <= S_IDLE;
         sel_q      <= '0;
         win_cnt    <= '0;
         settle_cnt <= '0;
         edge_cnt   <= '0;
         result_reg <= '0;
         done_flag  <= 1'b0;
         ovf_flag   <= 1'b0;
         ts_en_o    <= '0;
         irq_o      <= 1'b0;
      end else begin
         done_flag <= done_new;
         irq_o     <= done_new & irq_en_new;
         if (ovf_clr) ovf_flag <= 1'b0;
         if (busy && abort_w) begin
            state   <= S_IDLE;
            ts_en_o <= '0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start_ok) begin
                     state      <= S_SETTLE;
                     sel_q      <= sel_new;
                     win_cnt    <= window_reg;
                     settle_cnt <= '0;
                     edge_cnt   <= '0;
                     result_reg <= '0;
                     ovf_flag   <= 1'b0;
                     ts_en_o    <= onehot(sel_new);
                  end
               end
               S_SETTLE: begin
                  // Flush stale synchroniser contents; edges are not counted.
                  if (settle_cnt == ST_W'(SETTLE - 1)) begin
                     state <= (win_cnt == '0) ? S_DONE : S_COUNT;
                  end else begin
                     settle_cnt <= settle_cnt + ST_W'(1);
                  end
               end
               S_COUNT: begin
                  if (edge_det) begin
                     if (edge_cnt != CNT_MAX) edge_cnt <= edge_cnt + CNT_W'(1);
                     if (edge_cnt >= CNT_MAX - CNT_W'(1)) ovf_flag <= 1'b1;
                  end
                  win_cnt <= win_cnt - 32'd1;
                  if (win_cnt == 32'd1) state <= S_DONE;
               end
               default: begin
                  result_reg <= edge_cnt;
                  ts_en_o    <= '0;
                  state      <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ts_freq_counter.sv
// Bench for ts_freq_counter: bus driver tasks, a toggling test-structure
// generator, and one task per scenario compared against values derived from
// the register map and timing rules.
module tb_ts_freq_counter;

   localparam logic [31:0] BASE   = 32'h3000_0000;
   localparam int          SETTLE = 4;
   localparam int          CNT_W  = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] ts_in = '0;
   logic [7:0] ts_en;
   logic       irq;
   logic [1:0] state_dbg;

   int checks  = 0;
   int errors  = 0;
   int cyc_cnt = 0;
   int halfp[8];
   int tcnt[8];

   ts_freq_counter_if bus ();

   ts_freq_counter #(
      .N_CH(8), .CNT_W(CNT_W), .BASE_ADR(BASE), .SETTLE(SETTLE)
   ) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .wbs      (bus.slave),
      .ts_in    (ts_in),
      .ts_en_o  (ts_en),
      .irq_o    (irq),
      .state_dbg(state_dbg)
   );

   // Clock and cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   // Test-structure model: channel i toggles every halfp[i] clocks, offset
   // from the clock edge so it is asynchronous to the sampling flops.
   initial begin
      for (int i = 0; i < 8; i++) begin
         halfp[i] = 0;
         tcnt[i]  = 0;
      end
      forever begin
         @(posedge clk);
         #3;
         for (int i = 0; i < 8; i++) begin
            if (halfp[i] != 0) begin
               tcnt[i]++;
               if (tcnt[i] >= halfp[i]) begin
                  tcnt[i]  = 0;
                  ts_in[i] = ~ts_in[i];
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic bus_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                           input logic [3:0] sel, output logic [31:0] rdat, output int t_ack);
      int waits;
      @(posedge clk);
      #1;
      bus.wbs_cyc_i = 1'b1;
      bus.wbs_stb_i = 1'b1;
      bus.wbs_we_i  = we;
      bus.wbs_adr_i = adr;
      bus.wbs_dat_i = wdat;
      bus.wbs_sel_i = sel;
      rdat  = '0;
      t_ack = -1;
      waits = 0;
      @(negedge clk);
      checks++;
      if (bus.wbs_ack_o !== 1'b0) begin
         errors++;
         $display("FAIL ack_early adr=%h: got %b required 0", adr, bus.wbs_ack_o);
      end
      do begin
         @(negedge clk);
         waits++;
      end while (bus.wbs_ack_o !== 1'b1 && waits < 6);
      checks++;
      if (waits !== 1) begin
         errors++;
         $display("FAIL ack_latency adr=%h: got %0d cycles required 1", adr, waits);
      end
      if (bus.wbs_ack_o === 1'b1) begin
         rdat  = bus.wbs_dat_o;
         t_ack = cyc_cnt;
      end
      @(posedge clk);
      #1;
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_stb_i = 1'b0;
      bus.wbs_we_i  = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.wbs_ack_o !== 1'b0) begin
         errors++;
         $display("FAIL ack_width adr=%h: got %b required 0", adr, bus.wbs_ack_o);
      end
   endtask

   task automatic wb_write(input logic [31:0] off, input logic [31:0] wdat,
                           input logic [3:0] sel, output int t_ack);
      logic [31:0] dummy;
      bus_xfer(1'b1, BASE + off, wdat, sel, dummy, t_ack);
   endtask

   task automatic wb_read(input logic [31:0] off, output logic [31:0] rdat);
      int t;
      bus_xfer(1'b0, BASE + off, 32'h0, 4'hF, rdat, t);
   endtask

   task automatic wait_irq(input int limit, output int t_done);
      int n;
      n      = 0;
      t_done = -1;
      while (n < limit) begin
         @(negedge clk);
         n++;
         if (irq === 1'b1) begin
            t_done = cyc_cnt;
            break;
         end
      end
   endtask

   task automatic start_meas(input int ch, input int hp, input int win, output int t_start);
      int t;
      halfp[ch] = hp;
      wb_write(32'h4, win, 4'hF, t);
      wb_write(32'h0, (ch << 8) | 32'h3, 4'b0011, t_start);
   endtask

   task automatic finish_meas(input int limit, output int t_done,
                              output logic [31:0] res, output logic [31:0] status);
      wait_irq(limit, t_done);
      wb_read(32'h8, res);
      wb_read(32'hC, status);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      logic [31:0] rd;
      int acks;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checks++;
      if (ts_en !== 8'h00 || irq !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: got ts_en=%h irq=%b required 00/0", ts_en, irq);
      end
      for (int i = 0; i < 4; i++) begin
         wb_read(32'(4 * i), rd);
         checks++;
         if (rd !== 32'h0) begin
            errors++;
            $display("FAIL reset_reg%0d: got %h required 00000000", i, rd);
         end
      end
      // Address outside the block must never be acked.
      @(posedge clk);
      #1;
      bus.wbs_cyc_i = 1'b1;
      bus.wbs_stb_i = 1'b1;
      bus.wbs_adr_i = BASE + 32'h10;
      acks = 0;
      repeat (4) begin
         @(negedge clk);
         if (bus.wbs_ack_o === 1'b1) acks++;
      end
      @(posedge clk);
      #1;
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_stb_i = 1'b0;
      checks++;
      if (acks !== 0) begin
         errors++;
         $display("FAIL no_ack_mismatch: got %0d acks required 0", acks);
      end
   endtask

   task automatic test_window_bytes();
      logic [31:0] rd;
      int t;
      wb_write(32'h4, 32'h1234_5678, 4'b0010, t);
      wb_read(32'h4, rd);
      checks++;
      if (rd !== 32'h0000_5600) begin
         errors++;
         $display("FAIL window_byte1: got %h required 00005600", rd);
      end
      wb_write(32'h4, 32'hAABB_CCDD, 4'b1001, t);
      wb_read(32'h4, rd);
      checks++;
      if (rd !== 32'hAA00_56DD) begin
         errors++;
         $display("FAIL window_byte03: got %h required aa0056dd", rd);
      end
      wb_write(32'h8, 32'hFFFF_FFFF, 4'hF, t);
      wb_read(32'h8, rd);
      checks++;
      if (rd !== 32'h0) begin
         errors++;
         $display("FAIL result_ro: got %h required 00000000", rd);
      end
   endtask

   task automatic test_ctrl();
      logic [31:0] rd;
      int t;
      // START=0 and ABORT=0 with all other bits set: SEL=7, IRQ_EN=1 remain.
      wb_write(32'h0, 32'hFFFF_FFFA, 4'hF, t);
      wb_read(32'h0, rd);
      checks++;
      if (rd !== 32'h0000_0702) begin
         errors++;
         $display("FAIL ctrl_readback: got %h required 00000702", rd);
      end
      // START together with ABORT while idle: nothing starts.
      wb_write(32'h0, 32'h0000_0305, 4'b0011, t);
      @(negedge clk);
      checks++;
      if (ts_en !== 8'h00) begin
         errors++;
         $display("FAIL start_abort_en: got %h required 00", ts_en);
      end
      wb_read(32'hC, rd);
      checks++;
      if (rd !== 32'h0) begin
         errors++;
         $display("FAIL start_abort_status: got %h required 00000000", rd);
      end
   endtask

   task automatic test_measure();
      logic [31:0] res, st;
      int t0, td, t;
      start_meas(3, 4, 800, t0);
      repeat (20) @(negedge clk);
      checks++;
      if (ts_en !== 8'h08) begin
         errors++;
         $display("FAIL meas_ts_en: got %h required 08", ts_en);
      end
      finish_meas(900, td, res, st);
      checks++;
      if (td !== t0 + SETTLE + 800 + 2) begin
         errors++;
         $display("FAIL meas_done_time: got %0d required %0d", td - t0, SETTLE + 802);
      end
      checks++;
      if (res < 32'd99 || res > 32'd101) begin
         errors++;
         $display("FAIL meas_result: got %0d required 100+-1", res);
      end
      checks++;
      if (st !== 32'h2 || irq !== 1'b1 || ts_en !== 8'h00) begin
         errors++;
         $display("FAIL meas_status: got st=%h irq=%b en=%h required 2/1/00", st, irq, ts_en);
      end
      wb_write(32'hC, 32'h2, 4'h1, t);
      @(negedge clk);
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL irq_clear: got %b required 0", irq);
      end
   endtask

   task automatic test_zero_window();
      logic [31:0] res, st;
      int t0, td, t;
      start_meas(3, 4, 0, t0);
      finish_meas(50, td, res, st);
      checks++;
      if (td !== t0 + SETTLE + 2) begin
         errors++;
         $display("FAIL zero_done_time: got %0d required %0d", td - t0, SETTLE + 2);
      end
      checks++;
      if (res !== 32'h0 || st !== 32'h2) begin
         errors++;
         $display("FAIL zero_result: got res=%h st=%h required 0/2", res, st);
      end
      wb_write(32'hC, 32'h2, 4'h1, t);
   endtask

   task automatic test_abort();
      logic [31:0] rd;
      int t0, t, td;
      start_meas(3, 4, 800, t0);
      while (cyc_cnt < t0 + 90) @(negedge clk);
      // START while busy with a new SEL: ignored, but SEL is stored.
      wb_write(32'h0, 32'h0000_0503, 4'b0011, t);
      checks++;
      if (ts_en !== 8'h08) begin
         errors++;
         $display("FAIL busy_start_en: got %h required 08", ts_en);
      end
      wb_read(32'h0, rd);
      checks++;
      if (rd !== 32'h0000_0502) begin
         errors++;
         $display("FAIL busy_ctrl_sel: got %h required 00000502", rd);
      end
      wb_read(32'hC, rd);
      checks++;
      if (rd !== 32'h1) begin
         errors++;
         $display("FAIL busy_status: got %h required 00000001", rd);
      end
      wb_write(32'h0, 32'h0000_0006, 4'b0001, t);
      checks++;
      if (ts_en !== 8'h00 || irq !== 1'b0) begin
         errors++;
         $display("FAIL abort_outputs: got en=%h irq=%b required 00/0", ts_en, irq);
      end
      wb_read(32'hC, rd);
      checks++;
      if (rd !== 32'h0) begin
         errors++;
         $display("FAIL abort_status: got %h required 00000000", rd);
      end
      wb_read(32'h8, rd);
      checks++;
      if (rd !== 32'h0) begin
         errors++;
         $display("FAIL abort_result: got %h required 00000000", rd);
      end
      wait_irq(800, td);
      checks++;
      if (td !== -1) begin
         errors++;
         $display("FAIL abort_no_done: got irq at %0d required none", td);
      end
   endtask

   task automatic test_overflow();
      logic [31:0] res, st;
      int t0, td, t;
      start_meas(1, 2, 1200, t0);
      finish_meas(1300, td, res, st);
      checks++;
      if (res !== 32'd255 || st !== 32'h6) begin
         errors++;
         $display("FAIL ovf_result: got res=%0d st=%h required 255/6", res, st);
      end
      wb_write(32'hC, 32'h6, 4'h1, t);
      wb_read(32'hC, st);
      checks++;
      if (st !== 32'h0) begin
         errors++;
         $display("FAIL ovf_clear: got %h required 00000000", st);
      end
   endtask

   task automatic test_random();
      logic [31:0] res, st;
      int t0, td, t, ch, hp, win, per;
      for (int it = 0; it < 5; it++) begin
         for (int i = 0; i < 8; i++) halfp[i] = $urandom_range(2, 9);
         ch  = $urandom_range(0, 7);
         hp  = $urandom_range(2, 9);
         win = $urandom_range(16, 300);
         per = 2 * hp;
         start_meas(ch, hp, win, t0);
         checks++;
         if (ts_en !== 8'(1 << ch)) begin
            errors++;
            $display("FAIL rnd_ts_en ch=%0d: got %h required %h", ch, ts_en, 8'(1 << ch));
         end
         finish_meas(win + 50, td, res, st);
         checks++;
         if (td !== t0 + SETTLE + win + 2) begin
            errors++;
            $display("FAIL rnd_done_time win=%0d: got %0d required %0d", win, td - t0, SETTLE + win + 2);
         end
         // Rising edges in win cycles at period per lie within one of win/per.
         checks++;
         if (int'(res) * per + per < win || int'(res) * per > win + per || st !== 32'h2) begin
            errors++;
            $display("FAIL rnd_result win=%0d per=%0d: got res=%0d st=%h required ~%0d/2",
                     win, per, res, st, win / per);
         end
         wb_write(32'hC, 32'h2, 4'h1, t);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd;
      int t0;
      start_meas(2, 3, 500, t0);
      repeat (50) @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checks++;
      if (ts_en !== 8'h00 || irq !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_outputs: got en=%h irq=%b required 00/0", ts_en, irq);
      end
      for (int i = 0; i < 4; i++) begin
         wb_read(32'(4 * i), rd);
         checks++;
         if (rd !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset_reg%0d: got %h required 00000000", i, rd);
         end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_stb_i = 1'b0;
      bus.wbs_we_i  = 1'b0;
      bus.wbs_sel_i = 4'h0;
      bus.wbs_adr_i = 32'h0;
      bus.wbs_dat_i = 32'h0;
      test_reset();
      test_window_bytes();
      test_ctrl();
      test_measure();
      test_zero_window();
      test_abort();
      test_overflow();
      test_random();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ts_freq_counter.md
Name: ts_freq_counter

Overview:
Wishbone-slave measurement stage sitting directly downstream of gf180_teststructures inside user_project_wrapper.
- Enables one selected test structure (ring oscillator / toggling cell).
- Synchronises its output into wb_clk_i and counts rising edges over a programmable gate window of wb_clk_i cycles.
- Exposes the count to the management SoC over Wishbone, with an optional interrupt.

Parameters:
N_CH, 8, number of test-structure channels (1..16); SEL_W = max(1, clog2(N_CH)) derived
CNT_W, 32, result counter width (<=32); RESULT zero-extended to 32 bits
BASE_ADR, 32'h3000_0000, block base; decode is adr[31:4]==BASE_ADR[31:4]
SETTLE, 4, cycles of synchroniser flush after enable, counts discarded (>=3)

Ports:
wb_clk_i  input  1  system clock
wb_rst_i  input  1  synchronous reset, active-high
wbs_stb_i  input  1  Wishbone strobe
wbs_cyc_i  input  1  Wishbone cycle
wbs_we_i  input  1  write enable
wbs_sel_i  input  4  byte selects
wbs_adr_i  input  32  byte address
wbs_dat_i  input  32  write data
wbs_ack_o  output  1  acknowledge
wbs_dat_o  output  32  read data
ts_in  input  N_CH  raw test-structure outputs, asynchronous to wb_clk_i
ts_en_o  output  N_CH  one-hot enable for the selected structure
irq_o  output  1  measurement-done interrupt (level)

Behaviour:
Clock and reset:
- Clock is wb_clk_i; reset is wb_rst_i, synchronous and active-high.
- On reset all registers, outputs and the FSM clear to 0/IDLE: wbs_ack_o=0, wbs_dat_o=0, ts_en_o=0, irq_o=0.

Register map (offset = adr[3:2]):
- 0x0 CTRL: [0] START (W1, self-clearing, reads 0); [1] IRQ_EN; [2] ABORT (W1, reads 0); [8+:SEL_W] SEL.
- 0x4 WINDOW: RW, 32 bits.
- 0x8 RESULT: RO; writes are ignored.
- 0xC STATUS: [0] BUSY (RO); [1] DONE (W1C); [2] OVF (W1C).
- Unused bits read 0.

Wishbone:
- wbs_ack_o rises exactly 1 cycle after stb&cyc with address match and ack low, then drops for 1 cycle, so there is no back-to-back ack.
- No ack on address mismatch.
- wbs_dat_o is valid with ack and 0 otherwise.
- Writes honour wbs_sel_i per byte for CTRL and WINDOW. START/ABORT/W1C bits act only if byte 0 is selected.
- SEL values >= N_CH are stored, but a START with such a SEL is ignored.

Synchroniser:
- Only the selected channel is synchronised: 2-flop sync, then a 3rd flop for rising-edge detect.
- Correct counts require the input toggle rate to be below wb_clk_i/2.

FSM:
- IDLE: ts_en_o=0. A START write with BUSY=0 latches SEL->sel_q and WINDOW->win_cnt, clears RESULT, DONE and OVF, and enters SETTLE on the next cycle.
- SETTLE: ts_en_o = one-hot(sel_q); edges are ignored. Holds for SETTLE cycles, then goes to COUNT. If WINDOW=0 it goes to DONE instead.
- COUNT: ts_en_o held. Each cycle win_cnt is decremented and each detected edge increments edge_cnt. edge_cnt saturates at 2^CNT_W-1 and sets OVF when it saturates. The cycle with win_cnt==1 is the last counted cycle; next state is DONE.
- DONE (1 cycle): RESULT <= edge_cnt, DONE <= 1, ts_en_o <= 0, then IDLE.

Latency:
- START acked in cycle T.
- SETTLE occupies T+1..T+SETTLE; COUNT occupies WINDOW cycles.
- STATUS.DONE and RESULT are visible at T+SETTLE+WINDOW+2.

Other rules:
- BUSY = (state != IDLE).
- irq_o is registered: irq_o = DONE & IRQ_EN. It clears 1 cycle after a DONE W1C or an IRQ_EN clear.

Boundary conditions:
- START while BUSY is ignored, with no state change. A CTRL write while BUSY still updates IRQ_EN and SEL; the new SEL applies to the next measurement only.
- WINDOW writes while BUSY do not affect the running count.
- ABORT while BUSY returns to IDLE next cycle: ts_en_o=0, RESULT unchanged, DONE not set. ABORT while IDLE has no effect.
- START and ABORT in the same write: ABORT wins (IDLE).
- A DONE-W1C write in the same cycle as the FSM DONE state: set wins.
- wb_rst_i asserted mid-measurement returns everything to reset values next cycle.

Test Plan:
1. Reset, then read all 4 registers -> all read 0x0000_0000; ts_en_o=0, irq_o=0; read at BASE_ADR+0x10 -> no ack.
2. Write WINDOW=0x1234_5678 with wbs_sel_i=4'b0010, then read -> 0x0000_5600. Ack is 1 cycle wide on every access.
3. ts_in[3] toggles every 4 clk (period 8); CTRL: SEL=3, IRQ_EN=1, START; WINDOW=800 -> ts_en_o=8'h08 while BUSY; RESULT=100±1; STATUS=0x2; irq_o=1; DONE at T+806. Writing STATUS=0x2 then clears irq_o.
4. WINDOW=0, START -> DONE at T+6, RESULT=0, OVF=0.
5. Same setup as 3, ABORT written at T+100 -> BUSY=0 next cycle; RESULT keeps its previous value; DONE=0; irq_o=0. A second START while BUSY is ignored.
6. With CNT_W=8, ts_in toggling every 2 clk and WINDOW=1200 -> RESULT=255, STATUS=0x6.
